// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - Instruction prefetch queue with redirect flush; FETCH_QUEUE_STATS_EN adds flush/stall counters
module fetch_queue #(
    parameter int              PC_W     = 16,
    parameter int              INSTR_W  = 8,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc
`ifdef FETCH_QUEUE_STATS_EN
    ,
    output logic [15:0]        flush_count,
    output logic [15:0]        stall_count
`endif
);

    localparam int              PW      = $clog2(DEPTH);
    localparam int              CW      = $clog2(DEPTH + 1);
    localparam logic [PW-1:0]   LAST    = PW'(DEPTH - 1);
    localparam logic [CW:0]     DEPTH_C = (CW + 1)'(DEPTH);

    logic [INSTR_W-1:0] r_mem_instr [DEPTH];
    logic [PC_W-1:0]    r_mem_pc    [DEPTH];
    logic [PW-1:0]      r_rd_ptr;
    logic [PW-1:0]      r_wr_ptr;
    logic [CW-1:0]      r_count;
    logic [PC_W-1:0]    r_fetch_pc;
    logic               r_inflight;
    logic [PC_W-1:0]    r_inflight_pc;

    logic               w_deq;
    logic               w_issue;
    logic [CW:0]        w_occ;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // Occupancy counts the outstanding read, so a response always finds a free slot.
    assign w_deq       = instr_valid && instr_ready;
    assign w_occ       = {1'b0, r_count} + {{CW{1'b0}}, r_inflight} - {{CW{1'b0}}, w_deq};
    assign w_issue     = !reset && !redirect && (w_occ < DEPTH_C);

    assign imem_req    = w_issue;
    assign imem_addr   = r_fetch_pc;
    assign instr_valid = (r_count != '0);
    assign instr       = r_mem_instr[r_rd_ptr];
    assign instr_pc    = r_mem_pc[r_rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_instr[i] <= '0;
                r_mem_pc[i]    <= '0;
            end
        end else if (redirect) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
            r_fetch_pc <= redirect_pc;
        end else begin
            if (w_issue) begin
                r_fetch_pc    <= r_fetch_pc + 1'b1;
                r_inflight    <= 1'b1;
                r_inflight_pc <= r_fetch_pc;
            end else begin
                r_inflight <= 1'b0;
            end
            if (r_inflight) begin
                r_mem_instr[r_wr_ptr] <= imem_rdata;
                r_mem_pc[r_wr_ptr]    <= r_inflight_pc;
                r_wr_ptr              <= ptr_next(r_wr_ptr);
            end
            if (w_deq) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({r_inflight, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        (r_inflight && !redirect) |-> (r_count < CW'(DEPTH)));

`ifdef FETCH_QUEUE_STATS_EN
    logic w_flush;
    logic w_stall;

    assign w_flush = redirect && ((r_count != '0) || r_inflight);
    assign w_stall = instr_valid && !instr_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_count <= '0;
            stall_count <= '0;
        end else begin
            if (w_flush && (flush_count != 16'hFFFF)) begin
                flush_count <= flush_count + 1'b1;
            end
            if (w_stall && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - Vector-table bench for fetch_queue; honours FETCH_QUEUE_STATS_EN
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [7:0]  imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  instr;
    logic [15:0] instr_pc;
`ifdef FETCH_QUEUE_STATS_EN
    logic [15:0] flush_count;
    logic [15:0] stall_count;
`endif

    int checks = 0;
    int errors = 0;

    fetch_queue #(.PC_W(16), .INSTR_W(8), .DEPTH(4), .RESET_PC(16'h0000)) dut (
        .clk(clk),
        .reset(reset),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr(instr),
        .instr_pc(instr_pc)
`ifdef FETCH_QUEUE_STATS_EN
        ,
        .flush_count(flush_count),
        .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    // ROM contents: word at address a is a[7:0]
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= imem_addr[7:0];
    end

    typedef struct {
        logic        rdy;
        logic        red;
        logic [15:0] rpc;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_valid;
        logic [15:0] e_pc;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic rdy, input logic red, input logic [15:0] rpc,
                       input logic e_req, input logic [15:0] e_addr,
                       input logic e_valid, input logic [15:0] e_pc);
        vec_t v;
        v.rdy = rdy; v.red = red; v.rpc = rpc;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
        tv.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            instr_ready = tv[i].rdy;
            redirect    = tv[i].red;
            redirect_pc = tv[i].rpc;
            #1;
            chk($sformatf("v%0d imem_req", i), {31'b0, imem_req}, {31'b0, tv[i].e_req});
            if (tv[i].e_req)
                chk($sformatf("v%0d imem_addr", i), {16'b0, imem_addr}, {16'b0, tv[i].e_addr});
            chk($sformatf("v%0d instr_valid", i), {31'b0, instr_valid}, {31'b0, tv[i].e_valid});
            if (tv[i].e_valid) begin
                chk($sformatf("v%0d instr_pc", i), {16'b0, instr_pc}, {16'b0, tv[i].e_pc});
                chk($sformatf("v%0d instr", i), {24'b0, instr}, {24'b0, tv[i].e_pc[7:0]});
            end
`ifdef FETCH_QUEUE_STATS_EN
            if (i == 16) chk("stall_count", {16'b0, stall_count}, 32'd10);
            if (i == 21) chk("flush_count idle", {16'b0, flush_count}, 32'd0);
            if (i == 23) chk("flush_count one", {16'b0, flush_count}, 32'd1);
            if (i == 39) chk("flush_count three", {16'b0, flush_count}, 32'd3);
`endif
            @(negedge clk);
        end
    endtask

    initial begin
        // reset release, free stream from PC 0
        add(1, 0, 0, 1, 16'h0000, 0, 0);
        add(1, 0, 0, 1, 16'h0001, 0, 0);
        add(1, 0, 0, 1, 16'h0002, 1, 16'h0000);
        add(1, 0, 0, 1, 16'h0003, 1, 16'h0001);
        add(1, 0, 0, 1, 16'h0004, 1, 16'h0002);
        add(1, 0, 0, 1, 16'h0005, 1, 16'h0003);
        // ten cycles of backpressure
        add(0, 0, 0, 1, 16'h0006, 1, 16'h0004);
        add(0, 0, 0, 1, 16'h0007, 1, 16'h0004);
        for (int k = 0; k < 8; k++) add(0, 0, 0, 0, 16'h0000, 1, 16'h0004);
        add(1, 0, 0, 1, 16'h0008, 1, 16'h0004);
        add(1, 0, 0, 1, 16'h0009, 1, 16'h0005);
        add(1, 0, 0, 1, 16'h000A, 1, 16'h0006);
        add(1, 0, 0, 1, 16'h000B, 1, 16'h0007);
        // fill, then redirect to BEEF with FIFO full
        add(0, 0, 0, 0, 16'h0000, 1, 16'h0008);
        add(0, 0, 0, 0, 16'h0000, 1, 16'h0008);
        add(0, 1, 16'hBEEF, 0, 16'h0000, 1, 16'h0008);
        add(1, 0, 0, 1, 16'hBEEF, 0, 0);
        add(1, 0, 0, 1, 16'hBEF0, 0, 0);
        add(1, 0, 0, 1, 16'hBEF1, 1, 16'hBEEF);
        add(1, 0, 0, 1, 16'hBEF2, 1, 16'hBEF0);
        // redirect to FFFE, PC wraps
        add(1, 1, 16'hFFFE, 0, 16'h0000, 1, 16'hBEF1);
        add(1, 0, 0, 1, 16'hFFFE, 0, 0);
        add(1, 0, 0, 1, 16'hFFFF, 0, 0);
        add(1, 0, 0, 1, 16'h0000, 1, 16'hFFFE);
        add(1, 0, 0, 1, 16'h0001, 1, 16'hFFFF);
        add(1, 0, 0, 1, 16'h0002, 1, 16'h0000);
        add(1, 0, 0, 1, 16'h0003, 1, 16'h0001);
        // back-to-back redirects, deq in the first
        add(1, 1, 16'h0010, 0, 16'h0000, 1, 16'h0002);
        add(1, 1, 16'h0020, 0, 16'h0000, 0, 0);
        add(1, 0, 0, 1, 16'h0020, 0, 0);
        add(1, 0, 0, 1, 16'h0021, 0, 0);
        add(1, 0, 0, 1, 16'h0022, 1, 16'h0020);
        add(1, 0, 0, 1, 16'h0023, 1, 16'h0021);

        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("reset imem_req", {31'b0, imem_req}, 32'd0);
        chk("reset instr", {24'b0, instr}, 32'd0);
        chk("reset instr_pc", {16'b0, instr_pc}, 32'd0);
`ifdef FETCH_QUEUE_STATS_EN
        chk("reset flush_count", {16'b0, flush_count}, 32'd0);
        chk("reset stall_count", {16'b0, stall_count}, 32'd0);
`endif
        reset = 1'b0;
        run_vec(0, tv.size());

        // asynchronous reset mid-stream with a read outstanding
        instr_ready = 1'b1;
        redirect    = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midreset instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("midreset imem_req", {31'b0, imem_req}, 32'd0);
        chk("midreset instr_pc", {16'b0, instr_pc}, 32'd0);
`ifdef FETCH_QUEUE_STATS_EN
        chk("midreset flush_count", {16'b0, flush_count}, 32'd0);
        chk("midreset stall_count", {16'b0, stall_count}, 32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        run_vec(0, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised successor to the single-register fetch unit: decouples instruction fetch from decode with a DEPTH-entry prefetch FIFO.
- Sequential PC generation, one outstanding synchronous instruction-memory read, redirect (branch/loop jump) with flush of queued and in-flight fetches.
- Sits between instruction ROM and decode; valid/ready handshake toward decode.

Parameters:
PC_W, 16, program counter width
INSTR_W, 8, instruction word width
DEPTH, 4, prefetch FIFO entries (legal range 2..16)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
redirect  input  1  load new fetch PC, flush queue and in-flight read
redirect_pc  input  PC_W  target PC, sampled when redirect=1
imem_req  output  1  read request to instruction memory this cycle
imem_addr  output  PC_W  read address (current fetch PC)
imem_rdata  input  INSTR_W  read data, valid exactly 1 cycle after imem_req
instr_valid  output  1  head entry available to decode
instr_ready  input  1  decode accepts head entry
instr  output  INSTR_W  head instruction
instr_pc  output  PC_W  PC of head instruction

Behaviour:
- Reset values: fetch_pc=RESET_PC, count=0, inflight=0, imem_req=0, instr_valid=0, instr=0, instr_pc=0; FIFO pointers 0.
- State: fetch_pc, inflight flag plus captured inflight_pc, circular FIFO (rd_ptr, wr_ptr, count 0..DEPTH), each entry {instr, pc}.
- deq = instr_valid && instr_ready. instr_valid = (count != 0). instr/instr_pc driven from head entry, held stable while instr_valid && !instr_ready.
- Issue rule: imem_req = !redirect && (count + inflight - deq < DEPTH). imem_addr = fetch_pc. On issue: fetch_pc <= fetch_pc + 1, wrapping modulo 2^PC_W (all-ones -> 0); inflight <= 1; inflight_pc <= fetch_pc. Without issue, inflight <= 0.
- Response: when inflight=1 and no redirect this cycle, {imem_rdata, inflight_pc} is written at wr_ptr. The issue rule guarantees space; writing into a full FIFO is unreachable (assertion).
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance. Pointers wrap at DEPTH, including non-power-of-two values.
- Steady state with instr_ready=1: one instruction per cycle after initial latency.
- Redirect (highest priority): in the redirect cycle count<=0, pointers<=0, inflight<=0, the returning response is discarded, fetch_pc<=redirect_pc, and imem_req=0.
  - A deq occurring in the redirect cycle is a completed transfer; decode owns that instruction.
  - Back-to-back redirects: the last one wins; each one suppresses issue.
- Latency: redirect at cycle N -> imem_req with addr=redirect_pc at N+1 -> data at N+2 -> instr_valid=1, instr_pc=redirect_pc at N+3. Same 3-cycle latency after reset deassertion, starting from RESET_PC.
- Backpressure: with instr_ready=0, issue stops once count+inflight reaches DEPTH. No entry is lost or duplicated.
- Reset mid-operation: asynchronous clear. A read outstanding at reset is dropped because inflight=0.

Optional Feature:
- Macro FETCH_QUEUE_STATS_EN.
- Defined: adds output ports flush_count (16-bit) and stall_count (16-bit), both reset to 0.
  - flush_count increments on every redirect cycle in which count+inflight != 0 (useful work discarded).
  - stall_count increments on every cycle with instr_valid=1 and instr_ready=0.
  - Both saturate at 16'hFFFF.
- Undefined: the ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset, RESET_PC=0, instr_ready=1, ROM[i]=i -> instr_valid first high in 3rd cycle after reset release; instr/instr_pc = 0,1,2,3... one per cycle, no gaps.
- instr_ready=0 for 10 cycles after stream starts, DEPTH=4 -> imem_req drops after count+inflight=4; instr held at the same value; on release, pcs continue consecutively with none skipped.
- Redirect to 16'hBEEF with FIFO full -> instr_valid=0 at N+1 and N+2; instr_pc=16'hBEEF at N+3, then 16'hBEF0. Pre-redirect data never appears.
- fetch_pc=16'hFFFE, free run -> instr_pc sequence FFFE, FFFF, 0000, 0001.
- Redirect asserted on two consecutive cycles (targets 0x10 then 0x20) with deq in the first -> the dequeued head is accepted; next valid instr_pc=0x20; 0x10 is never fetched.
- With FETCH_QUEUE_STATS_EN: scenario 3 -> flush_count=1; scenario 2 -> stall_count=10.
